// File: rtl/task_sequencer.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | task_sequencer: walks enabled task slots, resets/starts the task manager  |
// | for each one and records pass / timeout results.          Rev 1.0         |
// +---------------------------------------------------------------------------+
module task_sequencer #(
  parameter int NUMBER_OF_TASKS = 16,
  parameter int TIMEOUT_CYCLES  = 65536,
  parameter int MGR_RST_CYCLES  = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        run_start,
  input  logic        run_abort,
  input  logic [31:0] enabled_tasks,
  input  logic        tasks_done,
  output logic [31:0] current_task_number,
  output logic        start_tests,
  output logic        mgr_rst,
  output logic        busy,
  output logic        run_done,
  output logic        run_aborted,
  output logic [31:0] pass_mask,
  output logic [31:0] timeout_mask
);

  localparam int IDX_W   = $clog2(NUMBER_OF_TASKS + 2);
  localparam int CNT_MAX = (TIMEOUT_CYCLES > MGR_RST_CYCLES) ? TIMEOUT_CYCLES : MGR_RST_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX);

  localparam logic [IDX_W-1:0] c_IDX_LAST  = IDX_W'(NUMBER_OF_TASKS);
  localparam logic [CNT_W-1:0] c_RST_LAST  = CNT_W'(MGR_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [63:0]      c_ONES      = (64'd1 << NUMBER_OF_TASKS) - 64'd1;
  localparam logic [31:0]      c_TASK_MASK = c_ONES[31:0];

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SEARCH    = 3'd1,
    S_MGR_RESET = 3'd2,
    S_START     = 3'd3,
    S_WAIT_DONE = 3'd4,
    S_NEXT      = 3'd5,
    S_DONE      = 3'd6,
    S_ABORT     = 3'd7
  } state_t;

  state_t           r_state, w_state_d;
  logic [IDX_W-1:0] r_idx, w_idx_d;
  logic [CNT_W-1:0] r_cnt, w_cnt_d;
  logic [31:0]      r_en, w_en_d;
  logic [31:0]      r_pass, w_pass_d;
  logic [31:0]      r_to, w_to_d;
  logic [31:0]      r_ctn, w_ctn_d;
  logic [31:0]      w_sel;
  logic             r_start, w_start_d;
  logic             r_mgr_rst, w_mgr_rst_d;
  logic             r_busy, w_busy_d;
  logic             r_done, w_done_d;
  logic             r_aborted, w_aborted_d;
  logic             w_in_run;

  // One-hot slot select for the current index; zero once the index runs past 32.
  assign w_sel    = 32'd1 << (r_idx - IDX_W'(1));
  assign w_in_run = (r_state == S_SEARCH) || (r_state == S_MGR_RESET) || (r_state == S_START) ||
                    (r_state == S_WAIT_DONE) || (r_state == S_NEXT);

  always_comb begin
    w_state_d = r_state;
    w_idx_d   = r_idx;
    w_cnt_d   = r_cnt;
    w_en_d    = r_en;
    w_pass_d  = r_pass;
    w_to_d    = r_to;

    case (r_state)
      S_IDLE: begin
        if (run_start) begin
          w_en_d    = enabled_tasks & c_TASK_MASK;
          w_pass_d  = '0;
          w_to_d    = '0;
          w_idx_d   = IDX_W'(1);
          w_cnt_d   = '0;
          w_state_d = S_SEARCH;
        end
      end
      S_SEARCH: begin
        if (r_idx > c_IDX_LAST) begin
          w_state_d = S_DONE;
        end else if ((r_en & w_sel) != 32'd0) begin
          w_state_d = S_MGR_RESET;
          w_cnt_d   = '0;
        end else begin
          w_idx_d = r_idx + IDX_W'(1);
        end
      end
      S_MGR_RESET: begin
        if (r_cnt == c_RST_LAST) begin
          w_state_d = S_START;
          w_cnt_d   = '0;
        end else begin
          w_cnt_d = r_cnt + CNT_W'(1);
        end
      end
      S_START: begin
        w_state_d = S_WAIT_DONE;
        w_cnt_d   = '0;
      end
      S_WAIT_DONE: begin
        // A done arriving on the last allowed cycle still counts as a pass.
        if (tasks_done) begin
          w_pass_d  = r_pass | w_sel;
          w_state_d = S_NEXT;
        end else if (r_cnt == c_TO_LAST) begin
          w_to_d    = r_to | w_sel;
          w_state_d = S_NEXT;
        end else begin
          w_cnt_d = r_cnt + CNT_W'(1);
        end
      end
      S_NEXT: begin
        w_idx_d   = r_idx + IDX_W'(1);
        w_state_d = S_SEARCH;
      end
      S_DONE:  w_state_d = S_IDLE;
      S_ABORT: w_state_d = S_IDLE;
      default: w_state_d = S_IDLE;
    endcase

    if (run_abort && w_in_run) begin
      w_state_d = S_ABORT;
      w_idx_d   = r_idx;
      w_cnt_d   = r_cnt;
      w_pass_d  = r_pass;
      w_to_d    = r_to;
    end

    // Outputs are a pure function of the upcoming state so they can be registered with it.
    w_busy_d    = (w_state_d == S_SEARCH) || (w_state_d == S_MGR_RESET) || (w_state_d == S_START) ||
                  (w_state_d == S_WAIT_DONE) || (w_state_d == S_NEXT);
    w_mgr_rst_d = (w_state_d == S_MGR_RESET) || (w_state_d == S_ABORT);
    w_start_d   = (w_state_d == S_START);
    w_done_d    = (w_state_d == S_DONE) || (w_state_d == S_ABORT);
    w_aborted_d = (w_state_d == S_ABORT);
    w_ctn_d     = ((w_state_d == S_MGR_RESET) || (w_state_d == S_START) || (w_state_d == S_WAIT_DONE)) ?
                  32'(w_idx_d) : 32'd0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_idx     <= IDX_W'(1);
      r_cnt     <= '0;
      r_en      <= '0;
      r_pass    <= '0;
      r_to      <= '0;
      r_ctn     <= '0;
      r_start   <= 1'b0;
      r_mgr_rst <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_idx     <= w_idx_d;
      r_cnt     <= w_cnt_d;
      r_en      <= w_en_d;
      r_pass    <= w_pass_d;
      r_to      <= w_to_d;
      r_ctn     <= w_ctn_d;
      r_start   <= w_start_d;
      r_mgr_rst <= w_mgr_rst_d;
      r_busy    <= w_busy_d;
      r_done    <= w_done_d;
      r_aborted <= w_aborted_d;
    end
  end

  assign current_task_number = r_ctn;
  assign start_tests         = r_start;
  assign mgr_rst             = r_mgr_rst;
  assign busy                = r_busy;
  assign run_done            = r_done;
  assign run_aborted         = r_aborted;
  assign pass_mask           = r_pass;
  assign timeout_mask        = r_to;

endmodule
`default_nettype wire

// File: tb/tb_task_sequencer.sv
`default_nettype none
// tb_task_sequencer: per-cycle expected-trace model of the sequencer plus a simple
// sticky-done task manager, with directed runs and literal result checks.
module tb_task_sequencer;

  localparam int NT = 16;
  localparam int TO = 20;
  localparam int MR = 4;

  logic        clk = 1'b0;
  logic        i_rst_n = 1'b1;
  logic        run_start = 1'b0;
  logic        run_abort = 1'b0;
  logic [31:0] enabled_tasks = 32'd0;
  logic        tasks_done;
  logic        inj = 1'b0;
  logic [31:0] current_task_number;
  logic        start_tests, mgr_rst, busy, run_done, run_aborted;
  logic [31:0] pass_mask, timeout_mask;

  task_sequencer #(
    .NUMBER_OF_TASKS(NT),
    .TIMEOUT_CYCLES (TO),
    .MGR_RST_CYCLES (MR)
  ) dut (
    .i_clk              (clk),
    .i_rst_n            (i_rst_n),
    .run_start          (run_start),
    .run_abort          (run_abort),
    .enabled_tasks      (enabled_tasks),
    .tasks_done         (tasks_done),
    .current_task_number(current_task_number),
    .start_tests        (start_tests),
    .mgr_rst            (mgr_rst),
    .busy               (busy),
    .run_done           (run_done),
    .run_aborted        (run_aborted),
    .pass_mask          (pass_mask),
    .timeout_mask       (timeout_mask)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] ctn;
    logic        st;
    logic        mr;
    logic        bz;
    logic        rd;
    logic        ra;
    logic [31:0] pm;
    logic [31:0] tm;
  } exp_t;

  exp_t        q[$];
  exp_t        cmp_e;
  logic [31:0] m_pass = 32'd0;
  logic [31:0] m_to   = 32'd0;
  bit          chk_en = 1'b0;
  int          n_chk = 0;
  int          n_err = 0;
  int          dly[0:NT];
  int          n_rd = 0;
  int          n_ra = 0;
  int          done_cyc = -1;
  int          start_log[$];

  // Task manager: sticky done dly[task] cycles after start_tests, cleared by mgr_rst.
  logic tm_act = 1'b0;
  int   tm_age = 0;
  int   tm_cur = 0;

  always @(posedge clk) begin
    if (mgr_rst) begin
      tm_act <= 1'b0;
      tm_age <= 0;
    end else if (start_tests) begin
      tm_act <= 1'b1;
      tm_age <= 1;
      tm_cur <= int'(current_task_number);
    end else if (tm_act) begin
      tm_age <= tm_age + 1;
    end
  end

  assign tasks_done = (tm_act && (dly[tm_cur] != 0) && (tm_age >= dly[tm_cur])) ||
                      (inj && (mgr_rst || start_tests));

  function automatic exp_t mk(input int ctn, input logic st, input logic mr, input logic bz,
                              input logic rd, input logic ra, input logic [31:0] pm, input logic [31:0] tm);
    exp_t e;
    e.ctn = 32'(ctn);
    e.st  = st;
    e.mr  = mr;
    e.bz  = bz;
    e.rd  = rd;
    e.ra  = ra;
    e.pm  = pm;
    e.tm  = tm;
    return e;
  endfunction

  function automatic exp_t act();
    return mk(int'(current_task_number), start_tests, mgr_rst, busy, run_done, run_aborted,
              pass_mask, timeout_mask);
  endfunction

  task automatic chk(input string nm, input logic [127:0] a, input logic [127:0] e);
    n_chk++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s @%0t: actual=%h required=%h", nm, $time, a, e);
    end
  endtask

  // Expected per-cycle trace of a run, from the cycle carrying run_start onward.
  task automatic build(input logic [31:0] en, input int abort_at);
    exp_t        t[$];
    exp_t        e;
    logic [31:0] men;
    logic [31:0] pm;
    logic [31:0] tm;
    men = en & ((32'd1 << NT) - 32'd1);
    pm  = 32'd0;
    tm  = 32'd0;
    q.push_back(mk(0, 0, 0, 0, 0, 0, m_pass, m_to));
    for (int i = 1; i <= NT + 1; i++) begin
      t.push_back(mk(0, 0, 0, 1, 0, 0, pm, tm));
      if (i > NT) break;
      if (men[i-1]) begin
        int  d;
        bit  ok;
        int  w;
        d  = dly[i];
        ok = (d >= 1) && (d <= TO);
        w  = ok ? d : TO;
        for (int k = 0; k < MR; k++) t.push_back(mk(i, 0, 1, 1, 0, 0, pm, tm));
        t.push_back(mk(i, 1, 0, 1, 0, 0, pm, tm));
        for (int k = 0; k < w; k++) t.push_back(mk(i, 0, 0, 1, 0, 0, pm, tm));
        if (ok) pm[i-1] = 1'b1;
        else    tm[i-1] = 1'b1;
        t.push_back(mk(0, 0, 0, 1, 0, 0, pm, tm));
      end
    end
    t.push_back(mk(0, 0, 0, 0, 1, 0, pm, tm));
    if (abort_at >= 0 && abort_at < t.size()) begin
      if (t[abort_at].bz) begin
        e = t[abort_at];
        while (t.size() > abort_at + 1) void'(t.pop_back());
        t.push_back(mk(0, 0, 1, 0, 1, 1, e.pm, e.tm));
      end
    end
    m_pass = t[t.size()-1].pm;
    m_to   = t[t.size()-1].tm;
    foreach (t[j]) q.push_back(t[j]);
  endtask

  task automatic run(input logic [31:0] en, input int abort_at, input int bsa, input int rst_at);
    int n;
    start_log.delete();
    n_rd     = 0;
    n_ra     = 0;
    done_cyc = -1;
    @(posedge clk); #1;
    enabled_tasks = en;
    run_start     = 1'b1;
    build(en, abort_at);
    n = q.size();
    for (int c = 1; c <= n + 1; c++) begin
      @(posedge clk); #1;
      run_start = (c == bsa);
      run_abort = (c == abort_at + 1);
      if (c == 1) enabled_tasks = ~en;
      if (run_done && done_cyc < 0) done_cyc = c;
      if (c == rst_at) begin
        chk_en = 1'b0;
        q.delete();
        i_rst_n = 1'b0;
        #1;
        chk("rst_async", 128'(act()), 128'(mk(0, 0, 1, 0, 0, 0, 0, 0)));
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hold", 128'(act()), 128'(mk(0, 0, 1, 0, 0, 0, 0, 0)));
        i_rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_release", 128'(act()), 128'(mk(0, 0, 0, 0, 0, 0, 0, 0)));
        m_pass = 32'd0;
        m_to   = 32'd0;
        chk_en = 1'b1;
        break;
      end
    end
    run_start = 1'b0;
    run_abort = 1'b0;
  endtask

  task automatic set_dly(input int d);
    for (int i = 0; i <= NT; i++) dly[i] = d;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        if (q.size() > 0) cmp_e = q.pop_front();
        else              cmp_e = mk(0, 0, 0, 0, 0, 0, m_pass, m_to);
        chk("cycle", 128'(act()), 128'(cmp_e));
      end
      if (start_tests) start_log.push_back(int'(current_task_number));
      if (run_done)    n_rd++;
      if (run_aborted) n_ra++;
    end
  end

  initial begin
    logic [127:0] v;
    set_dly(10);
    #1 i_rst_n = 1'b0;
    #2 chk("reset_vals", 128'(act()), 128'(mk(0, 0, 1, 0, 0, 0, 0, 0)));
    @(posedge clk); #1 i_rst_n = 1'b1;
    @(posedge clk); #1;
    chk("mgr_rst_release", 128'(act()), 128'(mk(0, 0, 0, 0, 0, 0, 0, 0)));
    chk_en = 1'b1;

    run(32'h0000_0211, -1, 0, 0);
    v = {32'(start_log.size()),
         (start_log.size() > 0) ? 32'(start_log[0]) : 32'hFFFF_FFFF,
         (start_log.size() > 1) ? 32'(start_log[1]) : 32'hFFFF_FFFF,
         (start_log.size() > 2) ? 32'(start_log[2]) : 32'hFFFF_FFFF};
    chk("r1_start_order", v, {32'd3, 32'd1, 32'd5, 32'd10});
    chk("r1_masks", 128'({pass_mask, timeout_mask, 32'(n_rd)}), 128'({32'h211, 32'h0, 32'd1}));

    dly[5] = 0;
    run(32'h0000_0211, -1, 0, 0);
    chk("r2_timeout", 128'({pass_mask, timeout_mask}), 128'({32'h201, 32'h10}));

    set_dly(10);
    run(32'h0, -1, 0, 0);
    chk("r3_empty", 128'({32'(done_cyc), 32'(start_log.size()), pass_mask, timeout_mask}),
        128'({32'd18, 32'd0, 32'd0, 32'd0}));

    run(32'h0000_0211, 30, 0, 0);
    chk("r4_abort", 128'({32'(n_rd), 32'(n_ra), pass_mask}), 128'({32'd1, 32'd1, 32'h1}));
    @(posedge clk); #1 run_abort = 1'b1;
    @(posedge clk); #1 run_abort = 1'b0;
    run(32'h0000_0211, -1, 5, 0);
    chk("r4_rerun", 128'({pass_mask, timeout_mask, 32'(n_ra)}), 128'({32'h211, 32'h0, 32'd0}));

    dly[1] = 3;
    run(32'h0000_0001, 26, 0, 0);
    chk("r5_abort_in_done", 128'({32'(n_rd), 32'(n_ra), pass_mask}), 128'({32'd1, 32'd0, 32'h1}));

    dly[2] = 20;
    dly[3] = 21;
    inj    = 1'b1;
    run(32'h0000_0006, -1, 0, 0);
    inj    = 1'b0;
    chk("r6_boundary", 128'({pass_mask, timeout_mask}), 128'({32'h2, 32'h4}));

    dly[16] = 2;
    run(32'hFFFF_8000, -1, 0, 0);
    chk("r7_top_slot", 128'({pass_mask, timeout_mask}), 128'({32'h8000, 32'h0}));

    set_dly(10);
    run(32'h0000_0211, -1, 0, 12);
    chk("r8_no_done", 128'(n_rd), 128'(0));
    dly[1] = 3;
    run(32'h0000_0001, -1, 0, 0);
    chk("r9_after_reset", 128'({pass_mask, timeout_mask}), 128'({32'h1, 32'h0}));

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
